// File: rtl/subblock_collector.sv
// Drains the three convolutional-encoder subblock FIFOs (d0, d1, d2) into one
// framed byte stream through a 2-entry skid buffer, honouring downstream backpressure.
module subblock_collector #(
  parameter int SMALL_BYTES = 132,
  parameter int LARGE_BYTES = 768,
  parameter int CNT_W       = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       blk_start,
  input  logic       blk_size,
  input  logic [7:0] q0,
  input  logic [7:0] q1,
  input  logic [7:0] q2,
  input  logic [2:0] empty,
  output logic [2:0] rdreq,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sop,
  output logic       out_eop,
  output logic       busy,
  output logic       blk_done
);

  typedef enum logic [2:0] {IDLE, S0, S1, S2, DRAIN} state_t;

  state_t           state_q, state_d, nxt_st;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             inflight_q;
  logic [1:0]       sel_q;
  logic [7:0]       skid_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       occ_q;
  logic             blk_done_q;

  logic [1:0]       stream;
  logic             in_rd, rd_ok, rd_en;
  logic             push, pop, done_d;
  logic [7:0]       push_data;

  assign out_valid = (occ_q != 2'd0);
  assign out_data  = skid_q[rd_ptr_q];
  assign out_sop   = out_valid && (out_cnt_q == '0);
  assign out_eop   = out_valid && (out_cnt_q == last_q);
  assign busy      = (state_q != IDLE);
  assign blk_done  = blk_done_q;

  assign pop    = out_valid && out_ready;
  assign push   = inflight_q;
  assign done_d = pop && out_eop && (state_q == DRAIN);

  // Read-side data mux follows the stream that issued the read, not the current state.
  always_comb begin
    case (sel_q)
      2'd0:    push_data = q0;
      2'd1:    push_data = q1;
      default: push_data = q2;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    last_d    = last_q;
    rd_cnt_d  = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    in_rd     = 1'b0;
    stream    = 2'd0;
    nxt_st    = IDLE;

    case (state_q)
      IDLE: begin
        if (blk_start) begin
          n_d       = blk_size ? CNT_W'(LARGE_BYTES) : CNT_W'(SMALL_BYTES);
          last_d    = blk_size ? CNT_W'(3*LARGE_BYTES-1) : CNT_W'(3*SMALL_BYTES-1);
          rd_cnt_d  = '0;
          out_cnt_d = '0;
          state_d   = S0;
        end
      end
      S0: begin
        in_rd  = 1'b1;
        stream = 2'd0;
        nxt_st = S1;
      end
      S1: begin
        in_rd  = 1'b1;
        stream = 2'd1;
        nxt_st = S2;
      end
      S2: begin
        in_rd  = 1'b1;
        stream = 2'd2;
        nxt_st = DRAIN;
      end
      DRAIN: begin
        if (done_d) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rd_ok = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2;
    rd_en = in_rd && !empty[stream] && rd_ok;
    rdreq = rd_en ? (3'b001 << stream) : '0;

    if (rd_en) begin
      if (rd_cnt_q == n_q - 1'b1) begin
        rd_cnt_d = '0;
        state_d  = nxt_st;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
      end
    end

    if (pop) out_cnt_d = out_eop ? '0 : out_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      last_q     <= '0;
      rd_cnt_q   <= '0;
      out_cnt_q  <= '0;
      inflight_q <= 1'b0;
      sel_q      <= 2'd0;
      skid_q[0]  <= '0;
      skid_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
      blk_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      last_q     <= last_d;
      rd_cnt_q   <= rd_cnt_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= rd_en;
      sel_q      <= stream;
      blk_done_q <= done_d;
      if (push) begin
        skid_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

endmodule

// File: tb/tb_subblock_collector.sv
// Randomized bench for subblock_collector: FIFO models feed the DUT and every
// transfer is compared against the expected d0|d1|d2 byte order with framing.
module tb_subblock_collector;
  localparam int SB = 4;
  localparam int LB = 6;

  logic       clk = 1'b0;
  logic       reset, blk_start, blk_size, out_ready;
  logic [7:0] q0, q1, q2;
  logic [2:0] empty, rdreq;
  logic [7:0] out_data;
  logic       out_valid, out_sop, out_eop, busy, blk_done;

  always #5 clk = ~clk;

  subblock_collector #(.SMALL_BYTES(SB), .LARGE_BYTES(LB), .CNT_W(12)) dut (
    .clk(clk), .reset(reset), .blk_start(blk_start), .blk_size(blk_size),
    .q0(q0), .q1(q1), .q2(q2), .empty(empty), .rdreq(rdreq),
    .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
    .out_sop(out_sop), .out_eop(out_eop), .busy(busy), .blk_done(blk_done)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
  } beat_t;

  int         vectors = 0;
  int         errors  = 0;
  logic [7:0] fifo [3][$];
  beat_t      exp_q [$];
  int         occ_m, infl_m, force_left, force_arm, rd1_cnt, reads_total;
  bit         busy_m, done_m, done_seen, after_rst;
  bit         start_req, size_req, rst_req, prev_hold;
  int         ready_mode;
  logic [7:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    bit    xfer, eopx;
    int    pend;
    beat_t b;
    @(negedge clk);
    reset     = rst_req;
    blk_start = start_req;
    blk_size  = size_req;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (rst_req) out_ready = 1'b0;
    for (int k = 0; k < 3; k++) empty[k] = (fifo[k].size() == 0);
    if (force_left > 0) empty[1] = 1'b1;
    #1;
    if (after_rst) begin
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sop", out_sop, 0);
      chk("rst_out_eop", out_eop, 0);
      after_rst = 0;
    end
    chk("rdreq_onehot0", $onehot0(rdreq), 1);
    if (occ_m + infl_m >= 2) chk("rdreq_when_full", rdreq, 0);
    if (force_left > 0)      chk("rdreq_when_empty", rdreq, 0);
    if (!busy_m)             chk("rdreq_when_idle", rdreq, 0);
    chk("occupancy_le2", occ_m <= 2, 1);
    chk("out_valid", out_valid, occ_m > 0);
    chk("busy", busy, busy_m);
    chk("blk_done", blk_done, done_m);
    done_seen = done_m;
    if (prev_hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, prev_data);
    end
    if (!out_valid) begin
      chk("sop_idle", out_sop, 0);
      chk("eop_idle", out_eop, 0);
    end
    xfer = out_valid && out_ready;
    eopx = 0;
    if (xfer) begin
      chk("xfer_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        chk("out_data", out_data, b.d);
        chk("out_sop", out_sop, b.sop);
        chk("out_eop", out_eop, b.eop);
        eopx = b.eop;
      end
    end
    prev_hold = out_valid && !out_ready && !rst_req;
    prev_data = out_data;
    pend = -1;
    for (int k = 0; k < 3; k++) if (rdreq[k]) pend = k;
    if (pend >= 0) begin
      chk("read_nonempty", fifo[pend].size() > 0, 1);
      reads_total++;
    end
    if (force_left > 0) force_left--;
    if (rdreq[1]) begin
      rd1_cnt++;
      if (rd1_cnt == force_arm) force_left = 5;
    end

    @(posedge clk);
    #1;
    if (rst_req) begin
      occ_m = 0; infl_m = 0; busy_m = 0; done_m = 0;
      exp_q.delete(); prev_hold = 0; after_rst = 1;
    end else begin
      occ_m  = occ_m + infl_m - (xfer ? 1 : 0);
      infl_m = (pend >= 0) ? 1 : 0;
      done_m = eopx;
      if (eopx) busy_m = 0;
      else if (start_req && !busy_m) busy_m = 1;
    end
    if (pend >= 0 && fifo[pend].size() > 0) begin
      case (pend)
        0:       q0 = fifo[0].pop_front();
        1:       q1 = fifo[1].pop_front();
        default: q2 = fifo[2].pop_front();
      endcase
    end
    start_req = 0;
    rst_req   = 0;
  endtask

  task automatic load_block(input bit size, input bit seq);
    int         n;
    logic [7:0] v;
    beat_t      b;
    n = size ? LB : SB;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < n; i++) begin
        v     = seq ? 8'(k * 16 + i) : 8'($urandom_range(0, 255));
        fifo[k].push_back(v);
        b.d   = v;
        b.sop = (k == 0 && i == 0);
        b.eop = (k == 2 && i == n - 1);
        exp_q.push_back(b);
      end
  endtask

  task automatic run_block(input bit size, input int rmode, input bit seq,
                           input int farm, input int extra_start);
    int n;
    n           = size ? LB : SB;
    load_block(size, seq);
    ready_mode  = rmode;
    force_arm   = farm;
    rd1_cnt     = 0;
    reads_total = 0;
    done_seen   = 0;
    start_req   = 1;
    size_req    = size;
    tick();
    for (int c = 0; c < 2000 && !done_seen; c++) begin
      if (c == extra_start) begin
        start_req = 1;
        size_req  = ~size;
      end
      tick();
    end
    chk("block_timeout", done_seen, 1);
    chk("reads_total", reads_total, 3 * n);
    chk("fifos_drained", fifo[0].size() + fifo[1].size() + fifo[2].size(), 0);
    chk("expected_drained", exp_q.size(), 0);
  endtask

  initial begin
    reset = 1'b1; blk_start = 1'b0; blk_size = 1'b0; out_ready = 1'b0;
    q0 = '0; q1 = '0; q2 = '0; empty = '1;
    occ_m = 0; infl_m = 0; force_left = 0; force_arm = 0; rd1_cnt = 0; reads_total = 0;
    busy_m = 0; done_m = 0; done_seen = 0; start_req = 0; size_req = 0; rst_req = 0;
    prev_hold = 0; prev_data = '0; ready_mode = 0;
    repeat (3) @(posedge clk);
    #1;
    after_rst = 1;
    repeat (2) tick();

    run_block(1'b0, 0, 1'b1, 0, -1);            // small, sequential, always ready
    run_block(1'b0, 1, 1'b1, 0, -1);            // ready toggling
    run_block(1'b1, 0, 1'b0, 2, -1);            // large, d1 starved after 2nd read
    run_block(1'b0, 2, 1'b0, 0, 3);             // stray blk_start while busy
    repeat (10) tick();

    // reset in the middle of stream 1
    load_block(1'b0, 1'b0);
    ready_mode = 2; force_arm = 0; rd1_cnt = 0;
    start_req = 1; size_req = 0;
    tick();
    for (int c = 0; c < 200 && rd1_cnt == 0; c++) tick();
    chk("reached_s1", rd1_cnt > 0, 1);
    rst_req = 1;
    tick();
    for (int k = 0; k < 3; k++) fifo[k].delete();
    tick();
    run_block(1'b0, 2, 1'b0, 0, -1);

    // back-to-back blocks with a size change
    run_block(1'b0, 2, 1'b0, 0, -1);
    run_block(1'b1, 2, 1'b0, 0, -1);

    for (int r = 0; r < 6; r++)
      run_block(1'($urandom_range(0, 1)), 2, 1'b0, ($urandom_range(0, 1) != 0) ? 3 : 0, -1);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
